ps2_key_receiver: RTL and testbench

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

---
 rtl/ps2_key_receiver_if.sv | 25 ++
 rtl/ps2_key_receiver.sv | 186 ++++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_receiver_if.sv
// Decoded keyboard output bundle from the PS/2 receiver to game logic.
// The receiver drives every signal; the consumer only reads them.
interface ps2_key_receiver_if;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic [4:0] key_held;
    logic [4:0] key_press;

    modport master (
        output scan_code,
        output code_valid,
        output frame_err,
        output key_held,
        output key_press
    );

    modport slave (
        input scan_code,
        input code_valid,
        input frame_err,
        input key_held,
        input key_press
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw bus, deframes 11-bit frames,
// and decodes E0/F0 prefixed scan codes into five game-key levels and press pulses.
module ps2_key_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_key_receiver_if.master    key_if
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_prev;
    logic            fall_c;
    logic            data_bit;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            code_load;
    logic            frame_bad;

    logic [7:0]      scan_code_q;
    logic            code_valid_q;
    logic            frame_err_q;

    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [4:0]      key_hit;
    logic [4:0]      held_q, held_d;
    logic [4:0]      press_q, press_d;

    // Two-flop synchronizers, reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall_c   = clk_prev & ~clk_sync[1];
    assign data_bit = data_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    // Frame FSM: advances on PS/2 falling edges; a stalled frame times out to IDLE.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        code_load = 1'b0;
        frame_bad = 1'b0;
        if (state_q != IDLE && to_cnt_q == TO_LAST && !fall_c) begin
            state_d   = IDLE;
            frame_bad = 1'b1;
        end else if (fall_c) begin
            case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {data_bit, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = data_bit;
                    state_d  = STOP;
                end
                STOP: begin
                    if (data_bit && (^{shift_q, parity_q})) begin
                        code_load = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q     <= '0;
            scan_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            to_cnt_q     <= (fall_c || state_q == IDLE) ? '0 : to_cnt_q + TO_W'(1);
            scan_code_q  <= code_load ? shift_q : scan_code_q;
            code_valid_q <= code_load;
            frame_err_q  <= frame_bad;
        end
    end

    // Scan-code decoder: E0/F0 are sticky prefixes consumed by the next plain code.
    always_comb begin
        key_hit = 5'b0;
        case (scan_code_q)
            8'h6B:   key_hit[0] = ext_q;
            8'h74:   key_hit[1] = ext_q;
            8'h72:   key_hit[2] = ext_q;
            8'h75:   key_hit[3] = ext_q;
            8'h29:   key_hit[4] = ~ext_q;
            default: key_hit = 5'b0;
        endcase
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        held_d  = held_q;
        press_d = 5'b0;
        if (code_valid_q) begin
            if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (brk_q) begin
                    held_d = held_q & ~key_hit;
                end else begin
                    held_d  = held_q | key_hit;
                    press_d = key_hit & ~held_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            held_q  <= 5'b0;
            press_q <= 5'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            held_q  <= held_d;
            press_q <= press_d;
        end
    end

    assign key_if.scan_code  = scan_code_q;
    assign key_if.code_valid = code_valid_q;
    assign key_if.frame_err  = frame_err_q;
    assign key_if.key_held   = held_q;
    assign key_if.key_press  = press_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: a scaled-rate PS/2 keyboard model drives
// frames while a negedge monitor counts output pulses.
module tb_ps2_key_receiver;

    localparam int unsigned TO_CYC = 1000;
    localparam int unsigned HALF   = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_receiver_if key_if ();

    ps2_key_receiver #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_if   (key_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cv_cnt = 0;
    int fe_cnt = 0;
    int kp_cnt [5] = '{default: 0};
    int bad_press = 0;
    logic [4:0] held_prev = 5'b0;

    // Pulse monitor; key_press must coincide exactly with a key_held rise.
    always @(negedge clk) begin
        if (!reset) begin
            if (key_if.code_valid) cv_cnt++;
            if (key_if.frame_err) fe_cnt++;
            for (int i = 0; i < 5; i++) begin
                if (key_if.key_press[i]) kp_cnt[i]++;
                if (key_if.key_press[i] != (key_if.key_held[i] & ~held_prev[i])) bad_press++;
            end
        end
        held_prev = key_if.key_held;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(1'b1);
        repeat (50) @(negedge clk);
    endtask

    int cv0, fe0, kp0, n;

    initial begin
        repeat (5) @(negedge clk);
        check("rst_scan", key_if.scan_code, 8'h00);
        check("rst_cv", key_if.code_valid, 1'b0);
        check("rst_fe", key_if.frame_err, 1'b0);
        check("rst_held", key_if.key_held, 5'b0);
        check("rst_press", key_if.key_press, 5'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x29 (drop press) with exact code_valid latency around the stop edge
        cv0 = cv_cnt; kp0 = kp_cnt[4]; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(((8'h29 >> i) & 8'h01) != 0);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk) check("cv_lat1", key_if.code_valid, 1'b0);
        @(negedge clk) check("cv_lat2", key_if.code_valid, 1'b0);
        @(negedge clk) check("cv_lat3", key_if.code_valid, 1'b1);
        @(negedge clk) check("cv_lat4", key_if.code_valid, 1'b0);
        repeat (HALF - 4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        check("f29_scan", key_if.scan_code, 8'h29);
        check("f29_cv", cv_cnt - cv0, 1);
        check("f29_fe", fe_cnt - fe0, 0);
        check("f29_held", key_if.key_held, 5'b10000);
        check("f29_press", kp_cnt[4] - kp0, 1);

        // Extended left press then extended break
        kp0 = kp_cnt[0];
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("left_held", key_if.key_held, 5'b10001);
        check("left_press", kp_cnt[0] - kp0, 1);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("left_rel", key_if.key_held, 5'b10000);
        check("left_rel_press", kp_cnt[0] - kp0, 1);

        // Bad parity
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h75, 1'b1);
        check("par_fe", fe_cnt - fe0, 1);
        check("par_cv", cv_cnt - cv0, 0);
        check("par_scan", key_if.scan_code, 8'h6B);
        check("par_held", key_if.key_held, 5'b10000);

        // Timeout after start + 3 data bits
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (key_if.frame_err) break;
        end
        check("to_lat", ((n >= 981) && (n <= 985)) ? 1 : 0, 1);
        repeat (20) @(negedge clk);
        check("to_fe", fe_cnt - fe0, 1);
        check("to_cv", cv_cnt - cv0, 0);
        kp0 = kp_cnt[4];
        send_frame(8'h29, 1'b0);
        check("to_next_scan", key_if.scan_code, 8'h29);
        check("to_next_cv", cv_cnt - cv0, 1);
        check("to_next_press", kp_cnt[4] - kp0, 0);

        // Typematic extended right
        kp0 = kp_cnt[1];
        for (int r = 0; r < 3; r++) begin
            send_frame(8'hE0, 1'b0);
            send_frame(8'h74, 1'b0);
            check("tm_held", key_if.key_held, 5'b10010);
        end
        check("tm_press", kp_cnt[1] - kp0, 1);

        // Reset mid-frame after 5 data bits
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_scan", key_if.scan_code, 8'h00);
        check("mid_held", key_if.key_held, 5'b0);
        check("mid_press", key_if.key_press, 5'b0);
        repeat (TO_CYC + 200) @(negedge clk);
        check("mid_fe", fe_cnt - fe0, 0);
        check("mid_cv", cv_cnt - cv0, 0);
        kp0 = kp_cnt[2];
        send_frame(8'hE0, 1'b0);
        send_frame(8'h72, 1'b0);
        check("down_held", key_if.key_held, 5'b00100);
        check("down_press", kp_cnt[2] - kp0, 1);
        check("press_align", bad_press, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
